alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
Multi-byte operation sequencer for the shared 8-bit combinational ALU. It accepts one wide operation (1..MAX_BYTES bytes) over a start/ready handshake and drives the ALU one byte per cycle, LSB first, chaining carry/borrow through the ALU flag input. It accumulates whole-word flags and returns result, flags and error with a one-cycle done pulse. The ALU is instantiated alongside it by the parent; this block only drives and samples it.

Parameters:
MAX_BYTES, 4, maximum operand width in bytes (>=1)
LEN_W, $clog2(MAX_BYTES)+1, width of len input

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
start  in  1  request valid; accepted only when ready=1
ready  out  1  high in IDLE only
op  in  7  one-hot ALU opcode: bit0 add, 1 sub, 2 and, 3 or, 4 not, 5 shl, 6 shr
len  in  LEN_W  operand length in bytes
opa  in  8*MAX_BYTES  operand A, byte 0 = bits 7:0
opb  in  8*MAX_BYTES  operand B
cin  in  1  initial carry/borrow (add/sub only)
done  out  1  one-cycle pulse, result valid
err  out  1  request rejected, valid with done, held
result  out  8*MAX_BYTES  wide result, held until next accept
flags  out  3  {pos, zero, carry}, held until next accept
alu_a, alu_b  out  8  ALU operand bytes
alu_fi  out  8  ALU flag input, {7'b0, carry_reg}
alu_op  out  7  ALU opcode
alu_d  in  8  ALU result byte
alu_fo  in  8  ALU flags, bit0 = carry/borrow

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (ports clk, rst).
- Reset: state IDLE, ready=1, done=0, err=0, result=0, flags=0, alu_op=0, alu_a=alu_b=alu_fi=0, byte index=0, carry_reg=0.
- FSM states:
  - IDLE -> EXEC on start&ready with a legal request.
  - IDLE -> DONE on start&ready with an illegal request.
  - EXEC -> DONE after byte len-1 is sampled.
  - DONE -> IDLE unconditionally.
- Legal request: op exactly one of bits 0..4 set, and 1 <= len <= MAX_BYTES. Any other op (zero, multi-hot, shl, shr) or len is illegal. Illegal: err=1, result=0, flags=0, done at T+1.
- Accept at cycle T latches op, len, opa, opb. carry_reg = cin for add/sub, 0 for all other ops. result is cleared to 0 and zero_acc set to 1.
- EXEC, byte i (cycles T+1..T+len):
  - Drive alu_a = opa byte i, alu_b = opb byte i, alu_op = op, alu_fi = {7'b0, carry_reg}.
  - On the clock edge: result byte i <= alu_d; carry_reg <= alu_fo[0] for add/sub, else 0; zero_acc &= (alu_d==0).
- alu_op = 0 outside EXEC.
- DONE (cycle T+len+1): done=1, err=0.
  - carry = final carry_reg.
  - zero = zero_acc.
  - pos = !zero & !(sign bit of byte len-1).
  - Result bytes >= len are 0.
- Latency: done at T+len+1; ready=1 again at T+len+2. start outside IDLE is ignored (not queued).
- result, flags and err hold after DONE until the next acceptance.
- Sub: borrow semantics follow the ALU (carry=1 means borrow), chained byte to byte.
- Not: unary; opb is ignored.
- rst in any state, including mid-EXEC: immediate return to reset values next edge; no done pulse for the aborted request.

Decomposition:
- Shared package alu_pkg:
  - one-hot op constants (OP_ADD .. OP_SHR)
  - flag bit indices (FLAG_CARRY=0, FLAG_ZERO=1, FLAG_POS=2)
  - state encoding for IDLE/EXEC/DONE
- No sub-module. The byte-select muxing and flag accumulation stay inline (about 150-250 lines).

Test Plan:
1. MAX_BYTES=4, add, len=2, opa=0x00FF, opb=0x0001, cin=0 -> done at T+3, result=0x00000100, carry=0, zero=0, pos=1, err=0.
2. Add, len=4, opa=0xFFFFFFFF, opb=0x00000001 -> done at T+5, result=0, carry=1, zero=1, pos=0; ready at T+6.
3. Sub, len=2, opa=0x0000, opb=0x0001, cin=0 -> result=0x0000FFFF, carry=1 (borrow), zero=0, pos=0.
4. And, len=2, opa=0xF0F0, opb=0x0FF0, cin=1 -> result=0x000000F0, carry=0 (cin ignored), pos=1. Upper bytes stay 0 when opa[31:16] is nonzero.
5. Illegal requests -> done at T+1, err=1, result=0, flags=0, alu_op stays 0 throughout. Cases: op=7'b0100000 (shl), op=7'b0000011, len=0, len=5.
6. Add len=4 accepted at T, rst high at T+2 -> IDLE and ready=1 at T+3, all outputs 0, no done pulse. A new start at T+3 completes normally; a start pulsed during EXEC is ignored.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the multi-byte ALU sequencer:
// one-hot opcodes, flag bit positions and FSM encoding.
package alu_pkg;

  localparam logic [6:0] OP_ADD = 7'b0000001;
  localparam logic [6:0] OP_SUB = 7'b0000010;
  localparam logic [6:0] OP_AND = 7'b0000100;
  localparam logic [6:0] OP_OR  = 7'b0001000;
  localparam logic [6:0] OP_NOT = 7'b0010000;
  localparam logic [6:0] OP_SHL = 7'b0100000;
  localparam logic [6:0] OP_SHR = 7'b1000000;

  localparam int FLAG_CARRY = 0;
  localparam int FLAG_ZERO  = 1;
  localparam int FLAG_POS   = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Shifts cannot be chained bytewise, so they are rejected.
  function automatic logic op_legal(
    input logic [6:0] op
  );
    return $onehot(op) &&
      ((op & (OP_SHL | OP_SHR)) == '0);
  endfunction

  function automatic logic op_chain(
    input logic [6:0] op
  );
    return (op & (OP_ADD | OP_SUB)) != '0;
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between a requester and
// the multi-byte ALU sequencer.
interface alu_seq_if #(
  parameter int MAX_BYTES = 4,
  parameter int LEN_W = $clog2(MAX_BYTES) + 1
);

  logic                   start;
  logic                   ready;
  logic [6:0]             op;
  logic [LEN_W-1:0]       len;
  logic [8*MAX_BYTES-1:0] opa;
  logic [8*MAX_BYTES-1:0] opb;
  logic                   cin;
  logic                   done;
  logic                   err;
  logic [8*MAX_BYTES-1:0] result;
  logic [2:0]             flags;

  modport master (
    output start, op, len, opa, opb, cin,
    input  ready, done, err, result, flags
  );

  modport slave (
    input  start, op, len, opa, opb, cin,
    output ready, done, err, result, flags
  );

endinterface

// File: rtl/alu_seq.sv
// Drives an external 8-bit ALU one byte per cycle,
// LSB first, chaining carry and accumulating flags.
module alu_seq
  import alu_pkg::*;
#(
  parameter int MAX_BYTES = 4,
  parameter int LEN_W = $clog2(MAX_BYTES) + 1
) (
  input  logic       clk,
  input  logic       rst,
  alu_seq_if.slave   bus,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [7:0] alu_fi,
  output logic [6:0] alu_op,
  input  logic [7:0] alu_d,
  input  logic [7:0] alu_fo
);

  localparam int W = 8 * MAX_BYTES;

  state_e           state_q, state_d;
  logic [6:0]       op_q, op_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [W-1:0]     opa_q, opa_d;
  logic [W-1:0]     opb_q, opb_d;
  logic [W-1:0]     result_q, result_d;
  logic [2:0]       flags_q, flags_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;

  logic       legal;
  logic       last;
  logic       exec;
  logic       c_new;
  logic       z_new;
  logic [7:0] a_byte;
  logic [7:0] b_byte;
  logic       unused_fo;

  assign unused_fo = |alu_fo[7:1];
  assign exec = (state_q == S_EXEC);
  assign last = (idx_q + LEN_W'(1)) == len_q;
  assign legal = op_legal(bus.op) &&
    (bus.len != '0) &&
    (bus.len <= LEN_W'(MAX_BYTES));
  assign c_new = op_chain(op_q) & alu_fo[0];
  assign z_new = zero_q & (alu_d == 8'h00);

  always_comb begin
    a_byte = '0;
    b_byte = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (idx_q == LEN_W'(i)) begin
        a_byte = opa_q[8*i +: 8];
        b_byte = opb_q[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    len_d    = len_q;
    idx_d    = idx_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    flags_d  = flags_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    err_d    = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d     = bus.op;
          len_d    = bus.len;
          opa_d    = bus.opa;
          opb_d    = bus.opb;
          idx_d    = '0;
          result_d = '0;
          flags_d  = '0;
          zero_d   = 1'b1;
          err_d    = !legal;
          carry_d  = legal & bus.cin &
                     op_chain(bus.op);
          state_d  = legal ? S_EXEC : S_DONE;
        end
      end
      S_EXEC: begin
        for (int i = 0; i < MAX_BYTES; i++) begin
          if (idx_q == LEN_W'(i)) begin
            result_d[8*i +: 8] = alu_d;
          end
        end
        carry_d = c_new;
        zero_d  = z_new;
        idx_d   = idx_q + LEN_W'(1);
        // Last byte carries the word's sign bit.
        if (last) begin
          flags_d[FLAG_CARRY] = c_new;
          flags_d[FLAG_ZERO]  = z_new;
          flags_d[FLAG_POS]   = !z_new & !alu_d[7];
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  assign bus.ready  = (state_q == S_IDLE);
  assign bus.done   = (state_q == S_DONE);
  assign bus.err    = err_q;
  assign bus.result = result_q;
  assign bus.flags  = flags_q;

  assign alu_op = exec ? op_q : '0;
  assign alu_a  = exec ? a_byte : '0;
  assign alu_b  = exec ? b_byte : '0;
  assign alu_fi = exec ? {7'b0, carry_q} : '0;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: emulated 8-bit ALU, word-level
// reference model and directed vectors.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int MB = 4;
  localparam int LW = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] alu_a, alu_b, alu_fi;
  logic [7:0] alu_d, alu_fo;
  logic [6:0] alu_op;
  logic       chk_on = 1'b0;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  alu_seq_if #(.MAX_BYTES(MB)) bus();

  alu_seq #(.MAX_BYTES(MB)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_fi(alu_fi),
    .alu_op(alu_op),
    .alu_d(alu_d),
    .alu_fo(alu_fo)
  );

  // Byte ALU the parent would instantiate.
  always_comb begin
    logic [8:0] t;
    t = '0;
    alu_d = '0;
    alu_fo = '0;
    case (alu_op)
      OP_ADD: begin
        t = {1'b0, alu_a} + {1'b0, alu_b} +
            {8'b0, alu_fi[0]};
        alu_d = t[7:0];
        alu_fo[0] = t[8];
      end
      OP_SUB: begin
        t = {1'b0, alu_a} - {1'b0, alu_b} -
            {8'b0, alu_fi[0]};
        alu_d = t[7:0];
        alu_fo[0] = t[8];
      end
      OP_AND: alu_d = alu_a & alu_b;
      OP_OR:  alu_d = alu_a | alu_b;
      OP_NOT: alu_d = ~alu_a;
      default: ;
    endcase
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  // Whole-word reference computed with wide arithmetic.
  function automatic void model(
    input  logic [6:0]  op,
    input  int          len,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] res,
    output logic [2:0]  fl,
    output logic        er,
    output int          lat
  );
    logic [63:0] mask, s, aa, bb;
    logic c, z, p;
    if (!(op inside {7'd1, 7'd2, 7'd4, 7'd8, 7'd16})
        || len < 1 || len > MB) begin
      res = '0; fl = '0; er = 1'b1; lat = 1;
      return;
    end
    mask = (64'd1 << (8 * len)) - 64'd1;
    aa = {32'b0, a} & mask;
    bb = {32'b0, b} & mask;
    c = 1'b0;
    s = '0;
    case (op)
      7'd1: begin
        s = aa + bb + {63'b0, cin};
        c = s[8 * len];
      end
      7'd2: begin
        s = aa - bb - {63'b0, cin};
        c = aa < (bb + {63'b0, cin});
      end
      7'd4:  s = aa & bb;
      7'd8:  s = aa | bb;
      default: s = ~aa;
    endcase
    res = 32'(s & mask);
    z = (res == 32'b0);
    p = !z && !res[8 * len - 1];
    fl = {p, z, c};
    er = 1'b0;
    lat = len + 1;
  endfunction

  int          m_left;
  logic [6:0]  m_op;
  logic [31:0] m_res;
  logic [2:0]  m_flags;
  logic        m_err;

  always @(posedge clk) begin
    logic [31:0] r;
    logic [2:0]  f;
    logic        e;
    int          l;
    if (rst) begin
      m_left  <= 0;
      m_op    <= '0;
      m_res   <= '0;
      m_flags <= '0;
      m_err   <= 1'b0;
    end else if (m_left == 0) begin
      if (bus.start) begin
        model(bus.op, int'(bus.len), bus.opa,
              bus.opb, bus.cin, r, f, e, l);
        m_left  <= l;
        m_op    <= bus.op;
        m_res   <= r;
        m_flags <= f;
        m_err   <= e;
      end
    end else begin
      m_left <= m_left - 1;
    end
  end

  always @(negedge clk) begin
    if (chk_on && !rst) begin
      chk("m.ready", bus.ready, m_left == 0);
      chk("m.done", bus.done, m_left == 1);
      chk("m.alu_op", alu_op,
          (m_left > 1) ? m_op : 7'b0);
      if (m_left <= 1) begin
        chk("m.result", bus.result, m_res);
        chk("m.flags", bus.flags, m_flags);
        chk("m.err", bus.err, m_err);
      end
    end
  end

  task automatic run(
    input string       nm,
    input logic [6:0]  op,
    input int          len,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        cin,
    input bit          pulse,
    input logic [31:0] er,
    input logic [2:0]  ef,
    input logic        ee,
    input int          elat
  );
    int n;
    bus.op = op;
    bus.len = LW'(len);
    bus.opa = a;
    bus.opb = b;
    bus.cin = cin;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (pulse && n == 1) begin
        bus.op = OP_NOT;
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
    end while (!bus.done && n < 20);
    bus.start = 1'b0;
    chk({nm, ".lat"}, n, elat);
    chk({nm, ".result"}, bus.result, er);
    chk({nm, ".flags"}, bus.flags, ef);
    chk({nm, ".err"}, bus.err, ee);
    @(negedge clk);
    chk({nm, ".ready"}, bus.ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: no finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.op = '0;
    bus.len = '0;
    bus.opa = '0;
    bus.opb = '0;
    bus.cin = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_on = 1'b1;
    @(negedge clk);
    chk("rst.ready", bus.ready, 1'b1);
    chk("rst.done", bus.done, 1'b0);
    chk("rst.result", bus.result, 32'h0);
    chk("rst.flags", bus.flags, 3'b000);
    chk("rst.err", bus.err, 1'b0);
    chk("rst.alu_op", alu_op, 7'h0);

    run("add2", OP_ADD, 2, 32'h00FF, 32'h0001, 1'b0,
        1'b0, 32'h00000100, 3'b100, 1'b0, 3);
    run("add4", OP_ADD, 4, 32'hFFFFFFFF, 32'h1, 1'b0,
        1'b0, 32'h0, 3'b011, 1'b0, 5);
    run("sub2", OP_SUB, 2, 32'h0, 32'h1, 1'b0,
        1'b0, 32'h0000FFFF, 3'b001, 1'b0, 3);
    run("and2", OP_AND, 2, 32'hABCDF0F0,
        32'hFFFF0FF0, 1'b1,
        1'b0, 32'h000000F0, 3'b100, 1'b0, 3);
    run("shl", OP_SHL, 2, 32'h1, 32'h1, 1'b0,
        1'b0, 32'h0, 3'b000, 1'b1, 1);
    run("multi", 7'b0000011, 2, 32'h1, 32'h1, 1'b0,
        1'b0, 32'h0, 3'b000, 1'b1, 1);
    run("len0", OP_ADD, 0, 32'h1, 32'h1, 1'b0,
        1'b0, 32'h0, 3'b000, 1'b1, 1);
    run("len5", OP_ADD, 5, 32'h1, 32'h1, 1'b0,
        1'b0, 32'h0, 3'b000, 1'b1, 1);
    run("or3", OP_OR, 3, 32'h00800000, 32'h1, 1'b0,
        1'b0, 32'h00800001, 3'b000, 1'b0, 4);
    run("not1", OP_NOT, 1, 32'h0F, 32'hFF, 1'b0,
        1'b0, 32'h000000F0, 3'b000, 1'b0, 2);
    run("addc3", OP_ADD, 3, 32'h0000FFFF, 32'h0, 1'b1,
        1'b1, 32'h00010000, 3'b100, 1'b0, 4);
    run("sub4", OP_SUB, 4, 32'h00010000, 32'h1, 1'b0,
        1'b0, 32'h0000FFFF, 3'b100, 1'b0, 5);

    bus.op = OP_ADD;
    bus.len = LW'(4);
    bus.opa = 32'h12345678;
    bus.opb = 32'h1;
    bus.cin = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.op = OP_OR;
    @(posedge clk);
    #1 bus.start = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort.ready", bus.ready, 1'b1);
    chk("abort.done", bus.done, 1'b0);
    chk("abort.result", bus.result, 32'h0);
    chk("abort.flags", bus.flags, 3'b000);
    chk("abort.err", bus.err, 1'b0);
    repeat (6) begin
      @(negedge clk);
      chk("abort.nodone", bus.done, 1'b0);
    end
    run("post", OP_ADD, 1, 32'h05, 32'h03, 1'b0,
        1'b0, 32'h00000008, 3'b100, 1'b0, 2);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
